mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one memory port (AR/R read channels, AW/W/B write channels) between two sort engines or a sort engine and a loader. It sits between the requesters' memory interfaces and the single memory slave. Read and write paths are arbitrated independently with round-robin fairness. A grant is held until its transaction completes: R beat for reads, B response for writes.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for a shared AR/R + AW/W/B memory port
// Read and write paths arbitrate independently; a grant holds until R beat / B response.
module mem_port_arbiter #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             m_ar_valid,
  output logic [1:0]             m_ar_ready,
  input  logic [2*ADDR_WDTH-1:0] m_ar_address,
  output logic [1:0]             m_r_valid,
  input  logic [1:0]             m_r_ready,
  output logic [DATA_WDTH-1:0]   m_r_data,
  output logic [RESP_WDTH-1:0]   m_r_resp,
  input  logic [1:0]             m_aw_valid,
  output logic [1:0]             m_aw_ready,
  input  logic [2*ADDR_WDTH-1:0] m_aw_address,
  input  logic [1:0]             m_w_valid,
  output logic [1:0]             m_w_ready,
  input  logic [2*DATA_WDTH-1:0] m_w_data,
  output logic [1:0]             m_b_valid,
  input  logic [1:0]             m_b_ready,
  output logic [RESP_WDTH-1:0]   m_b_resp,
  output logic                   ar_valid,
  output logic [ADDR_WDTH-1:0]   ar_address,
  input  logic                   ar_ready,
  input  logic                   r_valid,
  input  logic [DATA_WDTH-1:0]   r_data,
  input  logic [RESP_WDTH-1:0]   r_resp,
  output logic                   r_ready,
  output logic                   aw_valid,
  output logic [ADDR_WDTH-1:0]   aw_address,
  input  logic                   aw_ready,
  output logic                   w_valid,
  output logic [DATA_WDTH-1:0]   w_data,
  input  logic                   w_ready,
  input  logic                   b_valid,
  input  logic [RESP_WDTH-1:0]   b_resp,
  output logic                   b_ready,
  output logic [1:0]             rd_grant,
  output logic [1:0]             wr_grant
);

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_t;

  rd_state_t  r_rd_state, w_rd_state_nxt;
  wr_state_t  r_wr_state, w_wr_state_nxt;
  logic [1:0] r_rd_grant, w_rd_grant_nxt;
  logic [1:0] r_wr_grant, w_wr_grant_nxt;
  logic       r_rd_last, w_rd_last_nxt;
  logic       r_wr_last, w_wr_last_nxt;
  logic       r_aw_done, w_aw_done_nxt;
  logic       r_w_done, w_w_done_nxt;
  logic       w_rd_g, w_wr_g;
  logic       w_aw_hs, w_w_hs;

  // Returns the winning requester index; on a tie the one not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

  assign w_rd_g     = r_rd_grant[1];
  assign w_wr_g     = r_wr_grant[1];
  assign rd_grant   = r_rd_grant;
  assign wr_grant   = r_wr_grant;
  assign m_r_data   = r_data;
  assign m_r_resp   = r_resp;
  assign m_b_resp   = b_resp;
  assign ar_address = w_rd_g ? m_ar_address[2*ADDR_WDTH-1:ADDR_WDTH] : m_ar_address[ADDR_WDTH-1:0];
  assign aw_address = w_wr_g ? m_aw_address[2*ADDR_WDTH-1:ADDR_WDTH] : m_aw_address[ADDR_WDTH-1:0];
  assign w_data     = w_wr_g ? m_w_data[2*DATA_WDTH-1:DATA_WDTH] : m_w_data[DATA_WDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= RD_IDLE;
      r_rd_grant <= 2'b00;
      r_rd_last  <= 1'b1;
      r_wr_state <= WR_IDLE;
      r_wr_grant <= 2'b00;
      r_wr_last  <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_grant <= w_rd_grant_nxt;
      r_rd_last  <= w_rd_last_nxt;
      r_wr_state <= w_wr_state_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_wr_last  <= w_wr_last_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_grant_nxt = r_rd_grant;
    w_rd_last_nxt  = r_rd_last;
    ar_valid       = 1'b0;
    m_ar_ready     = 2'b00;
    m_r_valid      = 2'b00;
    r_ready        = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (|m_ar_valid) begin
          w_rd_grant_nxt = rr_pick(m_ar_valid, r_rd_last) ? 2'b10 : 2'b01;
          w_rd_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        ar_valid           = m_ar_valid[w_rd_g];
        m_ar_ready[w_rd_g] = ar_ready;
        if (m_ar_valid[w_rd_g] && ar_ready) w_rd_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        m_r_valid[w_rd_g] = r_valid;
        r_ready           = m_r_ready[w_rd_g];
        if (r_valid && m_r_ready[w_rd_g]) begin
          w_rd_last_nxt  = w_rd_g;
          w_rd_grant_nxt = 2'b00;
          w_rd_state_nxt = RD_IDLE;
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // AW and W complete independently; a finished channel is masked so it never handshakes twice.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_grant_nxt = r_wr_grant;
    w_wr_last_nxt  = r_wr_last;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    aw_valid       = 1'b0;
    w_valid        = 1'b0;
    m_aw_ready     = 2'b00;
    m_w_ready      = 2'b00;
    m_b_valid      = 2'b00;
    b_ready        = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (|(m_aw_valid | m_w_valid)) begin
          w_wr_grant_nxt = rr_pick(m_aw_valid | m_w_valid, r_wr_last) ? 2'b10 : 2'b01;
          w_wr_state_nxt = WR_XFER;
        end
      end
      WR_XFER: begin
        aw_valid           = m_aw_valid[w_wr_g] & ~r_aw_done;
        w_valid            = m_w_valid[w_wr_g] & ~r_w_done;
        m_aw_ready[w_wr_g] = aw_ready & ~r_aw_done;
        m_w_ready[w_wr_g]  = w_ready & ~r_w_done;
        w_aw_hs            = m_aw_valid[w_wr_g] & aw_ready & ~r_aw_done;
        w_w_hs             = m_w_valid[w_wr_g] & w_ready & ~r_w_done;
        w_aw_done_nxt      = r_aw_done | w_aw_hs;
        w_w_done_nxt       = r_w_done | w_w_hs;
        if (w_aw_done_nxt && w_w_done_nxt) w_wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_b_valid[w_wr_g] = b_valid;
        b_ready           = m_b_ready[w_wr_g];
        if (b_valid && m_b_ready[w_wr_g]) begin
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wr_last_nxt  = w_wr_g;
          w_wr_grant_nxt = 2'b00;
          w_wr_state_nxt = WR_IDLE;
        end
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
// Directed scenarios pin the model with literal expectations before the random run.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [7:0]  m_ar_address, m_aw_address;
  logic [31:0] m_r_data, r_data, w_data;
  logic [0:0]  m_r_resp, m_b_resp, r_resp, b_resp;
  logic [1:0]  m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic [63:0] m_w_data;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  ar_address, aw_address;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [1:0]  rd_grant, wr_grant;

  int checks = 0;
  int errors = 0;

  int rd_own, rd_last, wr_own, wr_last;
  bit rd_ad, aw_d, w_d;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_address(m_ar_address),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_address(m_aw_address),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .ar_valid(ar_valid), .ar_address(ar_address), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_address(aw_address), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
    .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rd_own = -1; rd_ad = 0; rd_last = 1;
    wr_own = -1; aw_d = 0; w_d = 0; wr_last = 1;
  endtask

  task automatic clear_inputs();
    m_ar_valid = 0; m_ar_address = 0; m_r_ready = 0;
    m_aw_valid = 0; m_aw_address = 0; m_w_valid = 0; m_w_data = 0; m_b_ready = 0;
    ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
  endtask

  // Settle, then compare every DUT output against what the model says the owner should see.
  task automatic eval();
    logic [1:0] e_rdg, e_wrg, e_arr, e_rv, e_awr, e_wr, e_bv;
    logic       e_arv, e_rr, e_awv, e_wv, e_br;
    #1;
    if (!rst_n) model_reset();
    e_rdg = 0; e_wrg = 0; e_arr = 0; e_rv = 0; e_awr = 0; e_wr = 0; e_bv = 0;
    e_arv = 0; e_rr = 0; e_awv = 0; e_wv = 0; e_br = 0;
    if (rd_own >= 0) begin
      e_rdg[rd_own] = 1'b1;
      if (!rd_ad) begin
        e_arv = m_ar_valid[rd_own];
        e_arr[rd_own] = ar_ready;
      end else begin
        e_rv[rd_own] = r_valid;
        e_rr = m_r_ready[rd_own];
      end
    end
    if (wr_own >= 0) begin
      e_wrg[wr_own] = 1'b1;
      if (!(aw_d && w_d)) begin
        e_awv = m_aw_valid[wr_own] && !aw_d;
        e_wv  = m_w_valid[wr_own] && !w_d;
        e_awr[wr_own] = aw_ready && !aw_d;
        e_wr[wr_own]  = w_ready && !w_d;
      end else begin
        e_bv[wr_own] = b_valid;
        e_br = m_b_ready[wr_own];
      end
    end
    chk("rd_grant", rd_grant, e_rdg);
    chk("wr_grant", wr_grant, e_wrg);
    chk("ar_valid", ar_valid, e_arv);
    chk("m_ar_ready", m_ar_ready, e_arr);
    chk("m_r_valid", m_r_valid, e_rv);
    chk("r_ready", r_ready, e_rr);
    chk("aw_valid", aw_valid, e_awv);
    chk("w_valid", w_valid, e_wv);
    chk("m_aw_ready", m_aw_ready, e_awr);
    chk("m_w_ready", m_w_ready, e_wr);
    chk("m_b_valid", m_b_valid, e_bv);
    chk("b_ready", b_ready, e_br);
    chk("m_r_data", m_r_data, r_data);
    chk("m_r_resp", m_r_resp, r_resp);
    chk("m_b_resp", m_b_resp, b_resp);
    if (e_arv) chk("ar_address", ar_address, m_ar_address[rd_own*4 +: 4]);
    if (e_awv) chk("aw_address", aw_address, m_aw_address[wr_own*4 +: 4]);
    if (e_wv)  chk("w_data", w_data, m_w_data[wr_own*32 +: 32]);
  endtask

  // Advance the transaction model by the handshakes visible this cycle, then clock.
  task automatic adv();
    logic [1:0] wreq;
    if (rst_n) begin
      if (rd_own < 0) begin
        if (m_ar_valid != 0) rd_own = (m_ar_valid == 2'b11) ? 1 - rd_last : (m_ar_valid[0] ? 0 : 1);
      end else if (!rd_ad) begin
        if (m_ar_valid[rd_own] && ar_ready) rd_ad = 1;
      end else if (r_valid && m_r_ready[rd_own]) begin
        rd_last = rd_own; rd_own = -1; rd_ad = 0;
      end
      wreq = m_aw_valid | m_w_valid;
      if (wr_own < 0) begin
        if (wreq != 0) wr_own = (wreq == 2'b11) ? 1 - wr_last : (wreq[0] ? 0 : 1);
      end else if (!(aw_d && w_d)) begin
        if (!aw_d && m_aw_valid[wr_own] && aw_ready) aw_d = 1;
        if (!w_d && m_w_valid[wr_own] && w_ready) w_d = 1;
      end else if (b_valid && m_b_ready[wr_own]) begin
        wr_last = wr_own; wr_own = -1; aw_d = 0; w_d = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    eval();
    chk("reset_rd_grant", rd_grant, 2'b00);
    chk("reset_ar_valid", ar_valid, 1'b0);
    adv(); adv();
    rst_n = 1'b1;

    // Single read from requester 1 at address 5.
    m_ar_valid = 2'b10; m_ar_address = 8'h50;
    eval(); chk("rd1_idle_grant", rd_grant, 2'b00); adv();
    ar_ready = 1;
    eval(); chk("rd1_grant", rd_grant, 2'b10); chk("rd1_ar_valid", ar_valid, 1'b1);
    chk("rd1_ar_address", ar_address, 4'h5); adv();
    m_ar_valid = 0; ar_ready = 0; r_valid = 1; r_data = 32'hDEAD_BEEF; m_r_ready = 2'b10;
    eval(); chk("rd1_m_r_valid", m_r_valid, 2'b10); chk("rd1_m_r_data", m_r_data, 32'hDEAD_BEEF);
    chk("rd1_r_ready", r_ready, 1'b1); adv();
    clear_inputs();
    eval(); chk("rd1_back_idle", rd_grant, 2'b00); adv();

    // Persistent tie: grants alternate 0,1,0,1 with one idle cycle between.
    m_ar_valid = 2'b11; m_ar_address = 8'h3C; ar_ready = 1; r_valid = 1; m_r_ready = 2'b11;
    for (int t = 0; t < 12; t++) begin
      eval();
      if (t % 3 == 1) chk("tie_grant", rd_grant, ((t / 3) % 2 == 1) ? 2'b10 : 2'b01);
      adv();
    end
    clear_inputs();
    eval(); adv();

    // Write from requester 0 with W accepted before AW.
    m_aw_valid = 2'b01; m_w_valid = 2'b01; m_aw_address = 8'h0A; m_w_data = 64'h0000_0000_1234_5678;
    eval(); adv();
    w_ready = 1;
    eval(); chk("wr_w_valid_c1", w_valid, 1'b1); chk("wr_aw_valid_c1", aw_valid, 1'b1); adv();
    eval(); chk("wr_w_valid_c2", w_valid, 1'b0); chk("wr_m_w_ready_c2", m_w_ready, 2'b00); adv();
    aw_ready = 1;
    eval(); chk("wr_aw_address", aw_address, 4'hA); adv();
    aw_ready = 0; w_ready = 0; b_valid = 1; b_resp = 1; m_b_ready = 2'b01;
    eval(); chk("wr_m_b_valid", m_b_valid, 2'b01); chk("wr_b_ready", b_ready, 1'b1);
    chk("wr_grant_resp", wr_grant, 2'b01); adv();
    clear_inputs();
    eval(); chk("wr_back_idle", wr_grant, 2'b00); adv();

    // Asynchronous reset during RD_DATA, then a stalled read with the other requester waiting.
    m_ar_valid = 2'b01; ar_ready = 1;
    eval(); adv();
    eval(); adv();
    m_ar_valid = 0; ar_ready = 0; r_valid = 1; m_r_ready = 2'b01;
    eval(); chk("pre_rst_r_ready", r_ready, 1'b1);
    rst_n = 1'b0;
    eval(); chk("rst_r_ready", r_ready, 1'b0); chk("rst_m_r_valid", m_r_valid, 2'b00);
    chk("rst_rd_grant", rd_grant, 2'b00);
    adv();
    rst_n = 1'b1; clear_inputs();
    m_ar_valid = 2'b01;
    eval(); adv();
    m_ar_valid = 2'b11;
    for (int t = 0; t < 5; t++) begin
      eval(); chk("stall_grant", rd_grant, 2'b01); chk("stall_m_ar_ready", m_ar_ready, 2'b00); adv();
    end
    ar_ready = 1;
    eval(); adv();
    ar_ready = 0; m_ar_valid = 0; r_valid = 1; m_r_ready = 2'b01;
    eval(); chk("stall_done_r", m_r_valid, 2'b01); adv();
    clear_inputs();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      m_ar_valid   = 2'($urandom_range(0, 3));
      m_ar_address = 8'($urandom);
      m_r_ready    = 2'($urandom_range(0, 3));
      m_aw_valid   = 2'($urandom_range(0, 3));
      m_aw_address = 8'($urandom);
      m_w_valid    = 2'($urandom_range(0, 3));
      m_w_data     = {$urandom, $urandom};
      m_b_ready    = 2'($urandom_range(0, 3));
      ar_ready     = 1'($urandom_range(0, 1));
      r_valid      = 1'($urandom_range(0, 1));
      r_data       = $urandom;
      r_resp       = 1'($urandom_range(0, 1));
      aw_ready     = 1'($urandom_range(0, 1));
      w_ready      = 1'($urandom_range(0, 1));
      b_valid      = 1'($urandom_range(0, 1));
      b_resp       = 1'($urandom_range(0, 1));
      eval();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
